// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - funct codes of the four accepted R-type instructions
//   - sequencer state encoding
//   - iteration counter width helper
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(DEF_WIDTH);

    // Within the accepted set, funct[1] selects divide and funct[0] selects unsigned.
    function automatic logic funct_valid(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: pipeline <-> HI/LO unit signal bundle.
//   master (pipeline/EX side): drives start, funct, rs_val, rt_val, read_hilo, cancel
//   slave  (muldiv unit):      drives busy, stall, done, div_zero, hi, lo
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             read_hilo;
    logic             cancel;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, funct, rs_val, rt_val, read_hilo, cancel,
        input  busy, stall, done, div_zero, hi, lo
    );

    modport slave (
        input  start, funct, rs_val, rt_val, read_hilo, cancel,
        output busy, stall, done, div_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiplier / restoring divider datapath.
//   clk        system clock
//   load       latch operand magnitudes and sign/zero flags, clear accumulator
//   step       perform one multiply or divide iteration
//   op_div     1 = divide, 0 = multiply (sampled on load)
//   op_signed  1 = signed operation (sampled on load)
//   rs_val     multiplicand / dividend
//   rt_val     multiplier / divisor
//   res_hi     sign-corrected HI result (valid after WIDTH steps)
//   res_lo     sign-corrected LO result
//   res_dz     latched divide-by-zero flag
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_dz
);

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic signed [WIDTH-1:0] rs_s, rt_s;
    logic                    rs_neg, rt_neg;

    // Multiply: acc = {partial product, multiplier}; divide: acc = {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q, negq_q, negr_q, dz_q;

    logic [WIDTH:0]     sum, shifted;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] acc_mul, acc_div, prod;
    logic [WIDTH-1:0]   quo, rem;

    assign rs_s   = $signed(rs_val);
    assign rt_s   = $signed(rt_val);
    assign rs_neg = op_signed && (rs_s < 0);
    assign rt_neg = op_signed && (rt_s < 0);

    // Multiply iteration: add multiplicand when the multiplier LSB is set, then shift right.
    assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign acc_mul = {sum, acc_q[WIDTH-1:1]};

    // Divide iteration: shift {rem,quo} left, trial subtract, keep the shifted value when
    // it is below the divisor. The modular WIDTH-bit difference is exact whenever ge is set.
    assign shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, opnd_q};
    assign diff    = shifted[WIDTH-1:0] - opnd_q;
    assign acc_div = {(ge ? diff : shifted[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};

    always_ff @(posedge clk) begin
        if (load) begin
            acc_q  <= {{WIDTH{1'b0}}, (op_div ? neg_if(rs_val, rs_neg) : neg_if(rt_val, rt_neg))};
            opnd_q <= op_div ? neg_if(rt_val, rt_neg) : neg_if(rs_val, rs_neg);
            div_q  <= op_div;
            negq_q <= rs_neg ^ rt_neg;
            negr_q <= rs_neg;
            dz_q   <= op_div && (rt_val == '0);
        end else if (step) begin
            acc_q  <= div_q ? acc_div : acc_mul;
        end
    end

    // With a zero divisor every trial subtract succeeds, so the remainder ends up holding
    // |rs|; restoring the dividend sign gives back the original rs_val.
    assign prod   = neg2_if(acc_q, negq_q);
    assign quo    = dz_q ? '1 : neg_if(acc_q[WIDTH-1:0], negq_q);
    assign rem    = neg_if(acc_q[2*WIDTH-1:WIDTH], negr_q);
    assign res_hi = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    assign res_lo = div_q ? quo : prod[WIDTH-1:0];
    assign res_dz = dz_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO unit for MIPS mult/multu/div/divu.
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     muldiv_if.slave: start/funct/rs_val/rt_val/read_hilo/cancel in;
//           busy/stall/done/div_zero/hi/lo out
// IDLE -> CALC (WIDTH iterations) -> FIX (write HI/LO, pulse done) -> IDLE.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept, load, step, fix_wr, busy;
    logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
    logic             done_q, dz_q, res_dz;

    assign accept = bus.start && !bus.cancel && funct_valid(bus.funct);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        fix_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = FIX;
                        cnt_d   = '0;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = '0;
                fix_wr  = !bus.cancel;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= fix_wr;
            dz_q    <= fix_wr && res_dz;
            if (fix_wr) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .load     (load),
        .step     (step),
        .op_div   (bus.funct[1]),
        .op_signed(!bus.funct[0]),
        .rs_val   (bus.rs_val),
        .rt_val   (bus.rt_val),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .res_dz   (res_dz)
    );

    // busy covers CALC and FIX, so a held start is only taken once the unit is back in IDLE.
    assign busy         = (state_q != IDLE);
    assign bus.busy     = busy;
    assign bus.stall    = busy && (bus.read_hilo || bus.start);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed-vector bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    muldiv_if #(.WIDTH(32)) mif ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        mif.start  = 1'b1;
        mif.funct  = f;
        mif.rs_val = rs;
        mif.rt_val = rt;
    endtask

    // Issue one op and follow it to completion at E0+33.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
        issue(f, rs, rt);
        tick();
        mif.start = 1'b0;
        chk({tag, " busy_e0"}, 64'(mif.busy), 64'd1);
        repeat (32) tick();
        chk({tag, " done_early"}, 64'(mif.done), 64'd0);
        tick();
        chk({tag, " done"}, 64'(mif.done), 64'd1);
        chk({tag, " busy_done"}, 64'(mif.busy), 64'd0);
        chk({tag, " hi"}, 64'(mif.hi), 64'(ehi));
        chk({tag, " lo"}, 64'(mif.lo), 64'(elo));
        chk({tag, " div_zero"}, 64'(mif.div_zero), 64'(edz));
        tick();
        chk({tag, " done_width"}, 64'(mif.done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        mif.start     = 1'b0;
        mif.funct     = '0;
        mif.rs_val    = '0;
        mif.rt_val    = '0;
        mif.read_hilo = 1'b0;
        mif.cancel    = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst hi", 64'(mif.hi), 64'd0);
        chk("rst lo", 64'(mif.lo), 64'd0);
        chk("rst busy", 64'(mif.busy), 64'd0);
        chk("rst done", 64'(mif.done), 64'd0);
        chk("rst dz", 64'(mif.div_zero), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_zero", FUNCT_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_plain", FUNCT_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0);

        // Non-mul/div funct is ignored.
        issue(6'b100000, 32'd1, 32'd1);
        tick();
        mif.start = 1'b0;
        chk("ignore_funct busy", 64'(mif.busy), 64'd0);

        // cancel together with start in IDLE: nothing starts.
        issue(FUNCT_MULT, 32'd2, 32'd2);
        mif.cancel = 1'b1;
        tick();
        mif.start  = 1'b0;
        mif.cancel = 1'b0;
        chk("cancel_start busy", 64'(mif.busy), 64'd0);

        // mfhi/mflo held from two cycles after start: stalls until the done cycle.
        issue(FUNCT_MULT, 32'd6, 32'd7);
        tick();
        mif.start = 1'b0;
        tick();
        mif.read_hilo = 1'b1;
        #1;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (mif.stall) n++;
            tick();
        end
        chk("rd_stall cycles", 64'(n), 64'd32);
        chk("rd_stall done", 64'(mif.done), 64'd1);
        chk("rd_stall stall_at_done", 64'(mif.stall), 64'd0);
        chk("rd_stall lo", 64'(mif.lo), 64'd42);
        chk("rd_stall hi", 64'(mif.hi), 64'd0);
        mif.read_hilo = 1'b0;
        tick();

        // Second start held during busy, accepted on the done (IDLE) edge.
        issue(FUNCT_MULTU, 32'd3, 32'd4);
        tick();
        issue(FUNCT_DIVU, 32'd100, 32'd7);
        #1;
        chk("held stall", 64'(mif.stall), 64'd1);
        repeat (32) tick();
        chk("held stall_fix", 64'(mif.stall), 64'd1);
        tick();
        chk("held done1", 64'(mif.done), 64'd1);
        chk("held lo1", 64'(mif.lo), 64'd12);
        chk("held stall_idle", 64'(mif.stall), 64'd0);
        tick();
        mif.start = 1'b0;
        chk("held busy2", 64'(mif.busy), 64'd1);
        repeat (32) tick();
        tick();
        chk("held done2", 64'(mif.done), 64'd1);
        chk("held lo2", 64'(mif.lo), 64'd14);
        chk("held hi2", 64'(mif.hi), 64'd2);
        tick();

        // cancel at iteration 10: back to IDLE, HI/LO untouched, no done.
        issue(FUNCT_MULT, 32'h1000, 32'h1000);
        tick();
        mif.start = 1'b0;
        repeat (10) tick();
        mif.cancel = 1'b1;
        tick();
        mif.cancel = 1'b0;
        chk("cancel busy", 64'(mif.busy), 64'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.done) n++;
            tick();
        end
        chk("cancel no_done", 64'(n), 64'd0);
        chk("cancel hi", 64'(mif.hi), 64'd2);
        chk("cancel lo", 64'(mif.lo), 64'd14);

        // Reset mid-operation at iteration 20.
        issue(FUNCT_MULT, 32'd5, 32'd5);
        tick();
        mif.start = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst hi", 64'(mif.hi), 64'd0);
        chk("midrst lo", 64'(mif.lo), 64'd0);
        chk("midrst busy", 64'(mif.busy), 64'd0);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.done) n++;
            tick();
        end
        chk("midrst no_done", 64'(n), 64'd0);
        chk("midrst lo_after", 64'(mif.lo), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
